// File: rtl/ysyx_22041207_hazard_ctrl.sv
// Pipeline hazard/stall controller: resolves memory-wait, multicycle-EX, redirect and
// load-use hazards by fixed priority, plus a saturating stall counter and sticky hang flag.
module ysyx_22041207_hazard_ctrl #(
  parameter int unsigned REDIRECT_FLUSH_CYCLES = 2,
  parameter int unsigned MAX_WAIT              = 64,
  parameter int unsigned CNT_W                 = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rwaddr,
  input  logic             ex_writeRD,
  input  logic             ex_memoryReadWen,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_count,
  output logic             hang_err
);

  localparam int unsigned RD_W = $clog2(REDIRECT_FLUSH_CYCLES + 1);
  localparam int unsigned WC_W = ($clog2(MAX_WAIT) < 1) ? 1 : $clog2(MAX_WAIT);

  localparam logic [RD_W-1:0] RD_RELOAD = RD_W'(REDIRECT_FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_EX_WAIT,
    ST_REDIRECT
  } state_e;

  state_e           state_q, state_d;
  logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hang_q, hang_d;

  logic stall_pc_c, bubble_ifid_c, bubble_idex_c, flush_ifid_c, flush_idex_c;
  logic ex_load_dst, rs1_hit, rs2_hit, load_use;

  // x0 never produces a hazard even if a load targets it.
  assign ex_load_dst = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0);
  assign rs1_hit     = id_uses_rs1 & (id_rs1addr == ex_rwaddr);
  assign rs2_hit     = id_uses_rs2 & (id_rs2addr == ex_rwaddr);
  assign load_use    = ex_load_dst & (rs1_hit | rs2_hit);

  always_comb begin
    stall_pc_c    = 1'b0;
    bubble_ifid_c = 1'b0;
    bubble_idex_c = 1'b0;
    flush_ifid_c  = 1'b0;
    flush_idex_c  = 1'b0;
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    hang_d        = hang_q;

    if (rst) begin
      state_d = ST_RUN;
    end else if (mem_busy) begin
      // Full freeze: sequencing state is held and EX events are dropped this cycle.
      stall_pc_c    = 1'b1;
      bubble_ifid_c = 1'b1;
      bubble_idex_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_EX_WAIT: begin
          if (ex_mc_done) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
          end else begin
            stall_pc_c    = 1'b1;
            bubble_ifid_c = 1'b1;
            bubble_idex_c = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
              hang_d = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
          end
        end

        ST_RUN: begin
          if (ex_mc_start) begin
            stall_pc_c    = 1'b1;
            bubble_ifid_c = 1'b1;
            bubble_idex_c = 1'b1;
            state_d       = ST_EX_WAIT;
            wait_cnt_d    = WC_W'(1);
          end else if (ex_redirect) begin
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
            if (REDIRECT_FLUSH_CYCLES > 1) begin
              state_d  = ST_REDIRECT;
              rd_cnt_d = RD_RELOAD;
            end
          end else if (load_use) begin
            stall_pc_c    = 1'b1;
            bubble_ifid_c = 1'b1;
            flush_idex_c  = 1'b1;
          end
        end

        ST_REDIRECT: begin
          flush_ifid_c = 1'b1;
          if (ex_redirect) begin
            flush_idex_c = 1'b1;
            rd_cnt_d     = RD_RELOAD;
          end else begin
            rd_cnt_d = rd_cnt_q - RD_W'(1);
            if (rd_cnt_q == RD_W'(1)) begin
              state_d = ST_RUN;
            end
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!rst && stall_pc_c && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      rd_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      hang_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      hang_q        <= hang_d;
    end
  end

  assign stall_pc    = stall_pc_c;
  assign bubble_ifid = bubble_ifid_c;
  assign bubble_idex = bubble_idex_c;
  assign flush_ifid  = flush_ifid_c;
  assign flush_idex  = flush_idex_c;
  assign stall_count = stall_count_q;
  assign hang_err    = hang_q;

  a_idex_excl: assert property (@(posedge clk) !(bubble_idex_c && flush_idex_c));
  a_ifid_excl: assert property (@(posedge clk) !(bubble_ifid_c && flush_ifid_c));

endmodule

// File: tb/tb_ysyx_22041207_hazard_ctrl.sv
// Bench for ysyx_22041207_hazard_ctrl: directed scenarios plus random stimulus against a
// cycle-level reference model, on two differently parameterised instances.
module tb_ysyx_22041207_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rw;
    logic       wrd;
    logic       ld;
    logic       redir;
    logic       mcs;
    logic       mcd;
    logic       mb;
  } in_t;

  // st: 0 = running, 1 = waiting on multicycle EX, 2 = draining a redirect
  typedef struct {
    int st;
    int rd;
    int wc;
    int cnt;
    bit hang;
  } mdl_t;

  logic clk, rst;
  logic [4:0] id_rs1addr, id_rs2addr, ex_rwaddr;
  logic id_uses_rs1, id_uses_rs2, ex_writeRD, ex_memoryReadWen;
  logic ex_redirect, ex_mc_start, ex_mc_done, mem_busy;

  logic a_spc, a_bif, a_bid, a_fif, a_fid, a_hang;
  logic [3:0] a_cnt;
  logic b_spc, b_bif, b_bid, b_fif, b_fid, b_hang;
  logic [7:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;
  mdl_t ma, mb;
  logic [4:0] obs_a;

  ysyx_22041207_hazard_ctrl #(
    .REDIRECT_FLUSH_CYCLES(2), .MAX_WAIT(4), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rwaddr(ex_rwaddr), .ex_writeRD(ex_writeRD), .ex_memoryReadWen(ex_memoryReadWen),
    .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .mem_busy(mem_busy),
    .stall_pc(a_spc), .bubble_ifid(a_bif), .bubble_idex(a_bid),
    .flush_ifid(a_fif), .flush_idex(a_fid),
    .stall_count(a_cnt), .hang_err(a_hang)
  );

  ysyx_22041207_hazard_ctrl #(
    .REDIRECT_FLUSH_CYCLES(3), .MAX_WAIT(6), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst(rst),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rwaddr(ex_rwaddr), .ex_writeRD(ex_writeRD), .ex_memoryReadWen(ex_memoryReadWen),
    .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .mem_busy(mem_busy),
    .stall_pc(b_spc), .bubble_ifid(b_bif), .bubble_idex(b_bid),
    .flush_ifid(b_fif), .flush_idex(b_fid),
    .stall_count(b_cnt), .hang_err(b_hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control vector order: {stall_pc, bubble_ifid, bubble_idex, flush_ifid, flush_idex}
  function automatic void mdl_eval(input mdl_t m, input logic r, input in_t v,
                                   input int rf, input int mw, input int cmax,
                                   output logic [4:0] ctl, output mdl_t n);
    bit lu;
    n   = m;
    ctl = 5'b00000;
    lu  = v.ld && v.wrd && (v.rw != 0) &&
          ((v.u1 && v.rs1 == v.rw) || (v.u2 && v.rs2 == v.rw));
    if (r) begin
      n.st = 0; n.rd = 0; n.wc = 0; n.cnt = 0; n.hang = 0;
      return;
    end
    if (v.mb) begin
      ctl = 5'b11100;
    end else if (m.st == 1) begin
      if (v.mcd) begin
        n.st = 0; n.wc = 0;
      end else begin
        ctl = 5'b11100;
        if (m.wc == mw - 1) n.hang = 1;
        else n.wc = m.wc + 1;
      end
    end else if (m.st == 0 && v.mcs) begin
      ctl = 5'b11100; n.st = 1; n.wc = 1;
    end else if (v.redir) begin
      ctl = 5'b00011;
      if (rf > 1) begin n.st = 2; n.rd = rf - 1; end
    end else if (m.st == 2) begin
      ctl = 5'b00010;
      n.rd = m.rd - 1;
      if (m.rd == 1) n.st = 0;
    end else if (lu) begin
      ctl = 5'b11001;
    end
    if (ctl[4] && m.cnt < cmax) n.cnt = m.cnt + 1;
  endfunction

  task automatic step(input logic r, input in_t v);
    logic [4:0] ea, eb;
    mdl_t na, nb;
    rst = r;
    id_rs1addr = v.rs1; id_rs2addr = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rwaddr = v.rw; ex_writeRD = v.wrd; ex_memoryReadWen = v.ld;
    ex_redirect = v.redir; ex_mc_start = v.mcs; ex_mc_done = v.mcd; mem_busy = v.mb;
    #1;
    mdl_eval(ma, r, v, 2, 4, 15, ea, na);
    mdl_eval(mb, r, v, 3, 6, 255, eb, nb);
    obs_a = {a_spc, a_bif, a_bid, a_fif, a_fid};
    check_eq("a_ctl", {27'd0, obs_a}, {27'd0, ea});
    check_eq("a_cnt", {28'd0, a_cnt}, ma.cnt);
    check_eq("a_hang", {31'd0, a_hang}, {31'd0, ma.hang});
    check_eq("b_ctl", {27'd0, b_spc, b_bif, b_bid, b_fif, b_fid}, {27'd0, eb});
    check_eq("b_cnt", {24'd0, b_cnt}, mb.cnt);
    check_eq("b_hang", {31'd0, b_hang}, {31'd0, mb.hang});
    @(posedge clk);
    ma = na;
    mb = nb;
    @(negedge clk);
  endtask

  function automatic in_t idle();
    in_t v = '0;
    return v;
  endfunction

  initial begin
    in_t v;
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    @(negedge clk);

    // reset state
    step(1'b1, idle());
    check_eq("rst_cnt", {28'd0, a_cnt}, 32'd0);

    // load-use on x5, then the same pattern targeting x0
    v = idle(); v.rw = 5'd5; v.ld = 1'b1; v.wrd = 1'b1; v.rs1 = 5'd5; v.rs2 = 5'd1; v.u1 = 1'b1;
    step(1'b0, v);
    check_eq("lu_ctl", {27'd0, obs_a}, 32'h19);
    check_eq("lu_cnt", {28'd0, a_cnt}, 32'd1);
    step(1'b0, idle());
    check_eq("lu_after", {27'd0, obs_a}, 32'h0);
    v.rw = 5'd0; v.rs1 = 5'd0;
    step(1'b0, v);
    check_eq("lu_x0", {27'd0, obs_a}, 32'h0);

    // redirect pulse
    step(1'b1, idle());
    v = idle(); v.redir = 1'b1;
    step(1'b0, v);
    check_eq("rd_c0", {27'd0, obs_a}, 32'h03);
    step(1'b0, idle());
    check_eq("rd_c1", {27'd0, obs_a}, 32'h02);
    step(1'b0, idle());
    check_eq("rd_c2", {27'd0, obs_a}, 32'h0);

    // multicycle with a redirect that must lose at t0
    step(1'b1, idle());
    v = idle(); v.mcs = 1'b1; v.redir = 1'b1;
    step(1'b0, v);
    check_eq("mc_t0", {27'd0, obs_a}, 32'h1c);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, idle());
      check_eq("mc_wait", {27'd0, obs_a}, 32'h1c);
    end
    v = idle(); v.mcd = 1'b1;
    step(1'b0, v);
    check_eq("mc_done", {27'd0, obs_a}, 32'h0);
    check_eq("mc_cnt_a", {28'd0, a_cnt}, 32'd5);
    check_eq("mc_cnt_b", {24'd0, b_cnt}, 32'd5);

    // memory wait during redirect drain
    step(1'b1, idle());
    v = idle(); v.redir = 1'b1;
    step(1'b0, v);
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.mb = 1'b1; v.redir = 1'b1;
      step(1'b0, v);
      check_eq("mb_freeze", {27'd0, obs_a}, 32'h1c);
    end
    step(1'b0, idle());
    check_eq("mb_resume", {27'd0, obs_a}, 32'h02);
    step(1'b0, idle());
    check_eq("mb_done", {27'd0, obs_a}, 32'h0);

    // hang detection and reset out of EX_WAIT
    step(1'b1, idle());
    v = idle(); v.mcs = 1'b1;
    step(1'b0, v);
    step(1'b0, idle());
    step(1'b0, idle());
    check_eq("hang_pre", {31'd0, a_hang}, 32'd0);
    step(1'b0, idle());
    check_eq("hang_set", {31'd0, a_hang}, 32'd1);
    step(1'b0, idle());
    check_eq("hang_sticky", {31'd0, a_hang}, 32'd1);
    step(1'b1, idle());
    check_eq("hang_rst_ctl", {27'd0, obs_a}, 32'h0);
    check_eq("hang_rst", {31'd0, a_hang}, 32'd0);
    step(1'b0, idle());
    check_eq("hang_run", {27'd0, obs_a}, 32'h0);

    // counter saturation
    step(1'b1, idle());
    for (int i = 0; i < 20; i++) begin
      v = idle(); v.mb = 1'b1;
      step(1'b0, v);
    end
    check_eq("sat_a", {28'd0, a_cnt}, 32'd15);
    check_eq("sat_b", {24'd0, b_cnt}, 32'd20);

    // random traffic
    step(1'b1, idle());
    for (int i = 0; i < 3000; i++) begin
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.rw    = 5'($urandom_range(0, 3));
      v.wrd   = ($urandom_range(0, 3) != 0);
      v.ld    = ($urandom_range(0, 1) != 0);
      v.redir = ($urandom_range(0, 7) == 0);
      v.mcs   = ($urandom_range(0, 9) == 0);
      v.mcd   = ($urandom_range(0, 5) == 0);
      v.mb    = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 199) == 0), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
